// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
// The command struct is sized from MEM_ADDR_W/MEM_DATA_W, which the top's parameters default to.
package data_mem_arb_pkg;

   localparam int NUM_PORTS  = 2;
   localparam int MEM_ADDR_W = 16;
   localparam int MEM_DATA_W = 16;

   typedef logic port_id_t;

   typedef struct packed {
      logic                  we;
      logic [MEM_ADDR_W-1:0] addr;
      logic [MEM_DATA_W-1:0] wdata;
      port_id_t              id;
   } mem_cmd_t;

   // Memory enable pair encoded as {mem_read, mem_write_en}
   localparam logic [1:0] CMD_IDLE = 2'b00;
   localparam logic [1:0] CMD_RD   = 2'b10;
   localparam logic [1:0] CMD_WR   = 2'b01;

   function automatic port_id_t onehot_to_id(input logic [NUM_PORTS-1:0] oh);
      return oh[1] & ~oh[0];
   endfunction

endpackage

// File: rtl/data_mem_arbiter_arb_pick2.sv
// Combinational two-way winner selection returning a one-hot grant.
// DATA_MEM_ARB_RR_EN selects round-robin (pointer input); otherwise port 0 has fixed priority.
module arb_pick2
   import data_mem_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
`ifdef DATA_MEM_ARB_RR_EN
   input  port_id_t             ptr,
`endif
   output logic [NUM_PORTS-1:0] gnt
);

`ifdef DATA_MEM_ARB_RR_EN
   // Only a genuine conflict consults the pointer; a lone request always wins
   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = ptr ? 2'b10 : 2'b01;
      end
   end
`else
   always_comb begin
      gnt = {req[1] & ~req[0], req[0]};
   end
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates two requesters onto the single-ported data memory: ARB -> ISSUE -> RET, two-cycle read latency.
// Define DATA_MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_access_addr,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic              busy
);

   logic [NUM_PORTS-1:0] req;
   logic [NUM_PORTS-1:0] pick;
   logic [NUM_PORTS-1:0] gnt;
   mem_cmd_t             win_cmd;
   mem_cmd_t             issue_cmd;
   logic                 issue_valid;
   logic [1:0]           issue_kind;

   assign req = {req1, req0};

`ifdef DATA_MEM_ARB_RR_EN
   port_id_t rr_ptr;

   // Pointer names the port that lost the last grant, so it wins the next conflict
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr <= 1'b0;
      end else if (|gnt) begin
         rr_ptr <= ~onehot_to_id(gnt);
      end
   end
`endif

   arb_pick2 u_pick (
      .req (req),
`ifdef DATA_MEM_ARB_RR_EN
      .ptr (rr_ptr),
`endif
      .gnt (pick)
   );

   assign gnt  = rst_n ? pick : '0;
   assign gnt0 = gnt[0];
   assign gnt1 = gnt[1];

   always_comb begin
      win_cmd = '{we: we0, addr: addr0, wdata: wdata0, id: 1'b0};
      if (gnt[1]) begin
         win_cmd = '{we: we1, addr: addr1, wdata: wdata1, id: 1'b1};
      end
   end

   // ISSUE stage: address and data keep their last values when nothing is granted
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         issue_valid <= 1'b0;
         issue_cmd   <= '0;
      end else begin
         issue_valid <= |gnt;
         if (|gnt) begin
            issue_cmd <= win_cmd;
         end
      end
   end

   assign issue_kind               = !issue_valid ? CMD_IDLE : (issue_cmd.we ? CMD_WR : CMD_RD);
   assign {mem_read, mem_write_en} = issue_kind;
   assign mem_access_addr          = issue_cmd.addr;
   assign mem_write_data           = issue_cmd.wdata;

   // RET stage: read data is steered to the port that issued it and held until its next read
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
         rdata0  <= '0;
         rdata1  <= '0;
      end else begin
         rvalid0 <= mem_read & ~issue_cmd.id;
         rvalid1 <= mem_read &  issue_cmd.id;
         if (mem_read && !issue_cmd.id) begin
            rdata0 <= mem_read_data;
         end
         if (mem_read && issue_cmd.id) begin
            rdata1 <= mem_read_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= 1'b0;
      end else begin
         busy <= (|gnt) | mem_read;
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised scoreboard bench for data_mem_arbiter with a behavioural memory and reference model.
// Build with DATA_MEM_ARB_RR_EN defined to check the round-robin variant.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

   typedef struct { bit we; logic [15:0] addr; logic [15:0] wdata; } req_t;
   typedef struct { logic [15:0] data; int due; } rsp_t;
   typedef struct { bit we; logic [15:0] addr; logic [15:0] wdata; int due; } cmd_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic        gnt0, gnt1, rvalid0, rvalid1, mem_write_en, mem_read, busy;
   logic [15:0] rdata0, rdata1, mem_access_addr, mem_write_data, mem_read_data;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   acc0 = 1'b0, acc1 = 1'b0;
   req_t pend0[$], pend1[$];
   rsp_t sb0[$], sb1[$];
   cmd_t cmdq[$];
   int   grant_log[$];
   int   wen_count = 0, rv0_count = 0, rv0_first = 0, rv0_last = 0;
   logic [15:0] refm [0:255];
   logic [15:0] exp_addr = '0, exp_wdata = '0, exp_rd0 = '0, exp_rd1 = '0;
`ifdef DATA_MEM_ARB_RR_EN
   int   rr_ptr = 0;
`endif

   logic [15:0] ram [0:255];
   bit          ram_init = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   data_mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
      .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
      .mem_write_en(mem_write_en), .mem_read(mem_read),
      .mem_read_data(mem_read_data), .busy(busy)
   );

   // Environment memory: combinational read, write on the clock edge, word index addr[8:1]
   assign mem_read_data = ram[mem_access_addr[8:1]];
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int w = 0; w < 256; w++) ram[w] <= 16'(3 * (w + 1));
         ram_init <= 1'b1;
      end else if (mem_write_en) begin
         ram[mem_access_addr[8:1]] <= mem_write_data;
      end
   end

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int pick(input logic r0, input logic r1);
      if (r0 && r1) begin
`ifdef DATA_MEM_ARB_RR_EN
         return rr_ptr;
`else
         return 0;
`endif
      end
      if (r0) return 0;
      if (r1) return 1;
      return -1;
   endfunction

   task automatic applyStimulus(input int port, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
      req_t r;
      r.we = we; r.addr = addr; r.wdata = wdata;
      if (port == 0) pend0.push_back(r);
      else pend1.push_back(r);
   endtask

   // Advance one cycle; a requester loads its next transaction only once the current one is accepted
   task automatic tick();
      req_t r;
      @(posedge clk);
      #1;
      if (!req0 || acc0) begin
         if (pend0.size() > 0) begin
            r = pend0.pop_front();
            req0 = 1'b1; we0 = r.we; addr0 = r.addr; wdata0 = r.wdata;
         end else req0 = 1'b0;
      end
      if (!req1 || acc1) begin
         if (pend1.size() > 0) begin
            r = pend1.pop_front();
            req1 = 1'b1; we1 = r.we; addr1 = r.addr; wdata1 = r.wdata;
         end else req1 = 1'b0;
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((pend0.size() > 0 || pend1.size() > 0 || req0 || req1 || sb0.size() > 0 ||
              sb1.size() > 0 || cmdq.size() > 0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) begin
         total++;
         bad++;
         $display("[TB] FAIL drain timeout after %0d cycles", budget);
      end
   endtask

   task automatic doReset(input int n);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      pend0.delete(); pend1.delete();
      repeat (n) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: compares pins, grants and read returns against the reference on every falling edge
   initial begin : monitor
      for (int w = 0; w < 256; w++) refm[w] = 16'(3 * (w + 1));
      forever begin
         @(negedge clk);
         begin
            bit          cmd_due, rv0_due, rv1_due, wr;
            int          win;
            logic [1:0]  exp_g;
            logic [15:0] a, d;
            cmd_t        c;
            rsp_t        s;
            cmd_due = (cmdq.size() > 0) && (cmdq[0].due == cyc);
            rv0_due = (sb0.size() > 0) && (sb0[0].due == cyc);
            rv1_due = (sb1.size() > 0) && (sb1[0].due == cyc);
            if (cmd_due) begin
               c = cmdq.pop_front();
               exp_addr = c.addr;
               exp_wdata = c.wdata;
               checkBit("mem_write_en", mem_write_en, c.we);
               checkBit("mem_read", mem_read, !c.we);
            end else begin
               checkBit("mem_write_en idle", mem_write_en, 1'b0);
               checkBit("mem_read idle", mem_read, 1'b0);
            end
            if (mem_write_en === 1'b1) wen_count++;
            checkOutput("mem_access_addr", mem_access_addr, exp_addr);
            checkOutput("mem_write_data", mem_write_data, exp_wdata);
            checkBit("busy", busy, cmd_due || rv0_due || rv1_due);

            checkBit("rvalid0", rvalid0, rv0_due);
            if (rv0_due) begin s = sb0.pop_front(); exp_rd0 = s.data; end
            if (rvalid0 === 1'b1) begin
               rv0_count++;
               if (rv0_count == 1) rv0_first = cyc;
               rv0_last = cyc;
            end
            checkOutput("rdata0", rdata0, exp_rd0);
            checkBit("rvalid1", rvalid1, rv1_due);
            if (rv1_due) begin s = sb1.pop_front(); exp_rd1 = s.data; end
            checkOutput("rdata1", rdata1, exp_rd1);

            exp_g = 2'b00;
            win = -1;
            if (rst_n === 1'b1) begin
               win = pick(req0, req1);
               if (win == 0) exp_g = 2'b01;
               else if (win == 1) exp_g = 2'b10;
            end
            checkOutput("gnt", 16'({gnt1, gnt0}), 16'(exp_g));
            acc0 = rst_n && req0 && gnt0;
            acc1 = rst_n && req1 && gnt1;

            if (win >= 0) begin
               grant_log.push_back(win);
               wr = (win == 0) ? we0 : we1;
               a  = (win == 0) ? addr0 : addr1;
               d  = (win == 0) ? wdata0 : wdata1;
               cmdq.push_back(cmd_t'{we: wr, addr: a, wdata: d, due: cyc + 1});
               if (wr) refm[a[8:1]] = d;
               else if (win == 0) sb0.push_back(rsp_t'{data: refm[a[8:1]], due: cyc + 2});
               else sb1.push_back(rsp_t'{data: refm[a[8:1]], due: cyc + 2});
`ifdef DATA_MEM_ARB_RR_EN
               rr_ptr = 1 - win;
`endif
            end

            if (rst_n !== 1'b1) begin
               cmdq.delete(); sb0.delete(); sb1.delete();
               exp_addr = '0; exp_wdata = '0; exp_rd0 = '0; exp_rd1 = '0;
`ifdef DATA_MEM_ARB_RR_EN
               rr_ptr = 0;
`endif
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin : main
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      $display("[TB] single reads");
      applyStimulus(0, 1'b0, 16'h0000, 16'h0000);
      drain(50);
      checkOutput("single read port0", rdata0, 16'h0003);
      applyStimulus(1, 1'b0, 16'h0002, 16'h0000);
      drain(50);
      checkOutput("single read port1", rdata1, 16'h0006);

      $display("[TB] write then read");
      wen_count = 0;
      applyStimulus(1, 1'b1, 16'h0010, 16'hBEEF);
      applyStimulus(1, 1'b0, 16'h0010, 16'h0000);
      drain(50);
      checkOutput("raw read data", rdata1, 16'hBEEF);
      checkOutput("write enable cycles", 16'(wen_count), 16'd1);

      $display("[TB] reset with read in issue");
      applyStimulus(0, 1'b0, 16'h0004, 16'h0000);
      tick();
      doReset(2);
      tick();

      $display("[TB] contention");
      grant_log.delete();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1'b0, 16'(4 * i), 16'h0000);
         applyStimulus(1, 1'b0, 16'(4 * i + 2), 16'h0000);
      end
      drain(60);
      checkOutput("contention grant count", 16'(grant_log.size()), 16'd8);
      for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
`ifdef DATA_MEM_ARB_RR_EN
         checkOutput("contention grant order", 16'(grant_log[i]), 16'(i % 2));
`else
         checkOutput("contention grant order", 16'(grant_log[i]), 16'(i / 4));
`endif
      end

      $display("[TB] streaming");
      rv0_count = 0;
      for (int i = 0; i < 16; i++) applyStimulus(0, 1'b0, 16'(2 * i), 16'h0000);
      drain(80);
      checkOutput("stream rvalid count", 16'(rv0_count), 16'd16);
      checkOutput("stream rvalid span", 16'(rv0_last - rv0_first), 16'd15);

      $display("[TB] idle");
      repeat (10) tick();
      checkBit("idle busy", busy, 1'b0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         if (pend0.size() == 0 && $urandom_range(0, 3) != 0)
            applyStimulus(0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom));
         if (pend1.size() == 0 && $urandom_range(0, 3) != 0)
            applyStimulus(1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom));
         tick();
      end
      drain(2000);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
